rocket_trace_buffer: RTL and testbench

// - Multi-lane retire-trace collector behind the tile's instruction broadcast port.
// - Each cycle, accepts up to NLANES retired-instruction records from the core and compacts them

---
 rtl/rocket_trace_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_rocket_trace_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rocket_trace_buffer.sv
// Multi-lane retire-trace collector: compacts up to NLANES records per cycle into one FIFO.
// Optional per-entry timestamp storage is enabled by defining RKT_TRACE_TIMESTAMP_EN.
module rocket_trace_buffer #(
  parameter int NLANES = 2,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset_ni,
  input  logic                     flush_i,
  input  logic [NLANES-1:0]        in_valid,
  input  logic [NLANES*XLEN-1:0]   in_iaddr,
  input  logic [NLANES*XLEN-1:0]   in_insn,
  input  logic [NLANES*3-1:0]      in_priv,
  input  logic [NLANES-1:0]        in_exception,
  input  logic [NLANES-1:0]        in_interrupt,
  input  logic [NLANES*XLEN-1:0]   in_cause,
  input  logic [NLANES*XLEN-1:0]   in_tval,
  input  logic [63:0]              in_time,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_iaddr,
  output logic [XLEN-1:0]          out_insn,
  output logic [XLEN-1:0]          out_cause,
  output logic [XLEN-1:0]          out_tval,
  output logic [2:0]               out_priv,
  output logic                     out_exception,
  output logic                     out_interrupt,
  output logic                     out_lost,
  output logic [63:0]              out_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic [LW-1:0] popcount(input logic [NLANES-1:0] v);
    logic [LW-1:0] cnt;
    cnt = {LW{1'b0}};
    for (int i = 0; i < NLANES; i++) begin
      cnt = cnt + LW'(v[i]);
    end
    return cnt;
  endfunction

  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [DROP_W-1:0] drop_count_r;
  logic              pending_r;

  logic [XLEN-1:0] iaddr_mem_r [DEPTH];
  logic [XLEN-1:0] insn_mem_r  [DEPTH];
  logic [XLEN-1:0] cause_mem_r [DEPTH];
  logic [XLEN-1:0] tval_mem_r  [DEPTH];
  logic [2:0]      priv_mem_r  [DEPTH];
  logic            exc_mem_r   [DEPTH];
  logic            int_mem_r   [DEPTH];
  logic            lost_mem_r  [DEPTH];

  logic [LW-1:0]     n_s;
  logic [LW-1:0]     free_s;
  logic [LW-1:0]     n_acc_s;
  logic [LW-1:0]     level_next_s;
  logic              accept_s;
  logic              drop_s;
  logic              pop_s;
  logic [DROP_W:0]   cnt_sum_s;
  logic [DROP_W-1:0] drop_next_s;
  logic [AW-1:0]     slot_s  [NLANES];
  logic              first_s [NLANES];

  assign out_valid = (level_r != {LW{1'b0}});

  // Group admission: free space is judged on occupancy before any same-cycle pop
  always_comb begin
    n_s    = popcount(in_valid);
    free_s = LW'(DEPTH) - level_r;
    pop_s  = out_valid && out_ready;
    accept_s = (n_s != {LW{1'b0}}) && (n_s <= free_s);
    drop_s   = (n_s != {LW{1'b0}}) && (n_s > free_s);
    if (accept_s) begin
      n_acc_s = n_s;
    end else begin
      n_acc_s = {LW{1'b0}};
    end
    level_next_s = level_r + n_acc_s - LW'(pop_s);
    cnt_sum_s    = {1'b0, drop_count_r} + (DROP_W+1)'(n_s);
    if (cnt_sum_s[DROP_W]) begin
      drop_next_s = {DROP_W{1'b1}};
    end else begin
      drop_next_s = cnt_sum_s[DROP_W-1:0];
    end
  end

  // Compaction: each valid lane lands after all lower valid lanes, skipping idle lanes
  always_comb begin : lane_slots
    logic [AW-1:0] run_v;
    run_v = {AW{1'b0}};
    for (int i = 0; i < NLANES; i++) begin
      slot_s[i]  = wr_ptr_r + run_v;
      first_s[i] = (run_v == {AW{1'b0}});
      run_v      = run_v + AW'(in_valid[i]);
    end
  end

  // Pointers, occupancy, saturating drop counter and pending-loss flag
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      level_r      <= {LW{1'b0}};
      drop_count_r <= {DROP_W{1'b0}};
      pending_r    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      level_r      <= {LW{1'b0}};
      drop_count_r <= {DROP_W{1'b0}};
      pending_r    <= 1'b0;
    end else begin
      level_r <= level_next_s;
      if (accept_s) begin
        wr_ptr_r  <= wr_ptr_r + AW'(n_s);
        pending_r <= 1'b0;
      end else if (drop_s) begin
        drop_count_r <= drop_next_s;
        pending_r    <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Record storage; entries are zeroed on reset so the idle head is never X
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int e = 0; e < DEPTH; e++) begin
        iaddr_mem_r[e] <= {XLEN{1'b0}};
        insn_mem_r[e]  <= {XLEN{1'b0}};
        cause_mem_r[e] <= {XLEN{1'b0}};
        tval_mem_r[e]  <= {XLEN{1'b0}};
        priv_mem_r[e]  <= 3'b000;
        exc_mem_r[e]   <= 1'b0;
        int_mem_r[e]   <= 1'b0;
        lost_mem_r[e]  <= 1'b0;
      end
    end else if (accept_s && !flush_i) begin
      for (int i = 0; i < NLANES; i++) begin
        if (in_valid[i]) begin
          iaddr_mem_r[slot_s[i]] <= in_iaddr[i*XLEN +: XLEN];
          insn_mem_r[slot_s[i]]  <= in_insn[i*XLEN +: XLEN];
          cause_mem_r[slot_s[i]] <= in_cause[i*XLEN +: XLEN];
          tval_mem_r[slot_s[i]]  <= in_tval[i*XLEN +: XLEN];
          priv_mem_r[slot_s[i]]  <= in_priv[i*3 +: 3];
          exc_mem_r[slot_s[i]]   <= in_exception[i];
          int_mem_r[slot_s[i]]   <= in_interrupt[i];
          lost_mem_r[slot_s[i]]  <= first_s[i] & pending_r;
        end
      end
    end
  end

`ifdef RKT_TRACE_TIMESTAMP_EN
  logic [63:0] time_mem_r [DEPTH];

  // Timestamp storage; every lane of a group shares the same sample
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int e = 0; e < DEPTH; e++) begin
        time_mem_r[e] <= 64'h0;
      end
    end else if (accept_s && !flush_i) begin
      for (int i = 0; i < NLANES; i++) begin
        if (in_valid[i]) begin
          time_mem_r[slot_s[i]] <= in_time;
        end
      end
    end
  end

  assign out_time = time_mem_r[rd_ptr_r];
`else
  logic unused_time_s;
  assign unused_time_s = ^in_time;
  assign out_time      = 64'h0;
`endif

  assign out_iaddr     = iaddr_mem_r[rd_ptr_r];
  assign out_insn      = insn_mem_r[rd_ptr_r];
  assign out_cause     = cause_mem_r[rd_ptr_r];
  assign out_tval      = tval_mem_r[rd_ptr_r];
  assign out_priv      = priv_mem_r[rd_ptr_r];
  assign out_exception = exc_mem_r[rd_ptr_r];
  assign out_interrupt = int_mem_r[rd_ptr_r];
  assign out_lost      = lost_mem_r[rd_ptr_r];
  assign level         = level_r;
  assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_rocket_trace_buffer.sv
// Bench for rocket_trace_buffer: queue-based record model checked every cycle plus directed literal checks.
module tb_rocket_trace_buffer;
  localparam int NL = 2;
  localparam int DP = 16;
`ifdef RKT_TRACE_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [63:0] in_iaddr = 64'h0, in_insn = 64'h0, in_cause = 64'h0, in_tval = 64'h0;
  logic [5:0]  in_priv = 6'h0;
  logic [1:0]  in_exception = 2'b00, in_interrupt = 2'b00;
  logic [63:0] in_time = 64'h0;

  logic        out_valid, out_exception, out_interrupt, out_lost;
  logic [31:0] out_iaddr, out_insn, out_cause, out_tval;
  logic [2:0]  out_priv;
  logic [63:0] out_time;
  logic [4:0]  level;
  logic [15:0] drop_count;

  logic        v4, ex4, it4, lo4;
  logic [31:0] ia4, is4, ca4, tv4;
  logic [2:0]  pr4;
  logic [63:0] ti4;
  logic [4:0]  lv4;
  logic [3:0]  dc4;

  rocket_trace_buffer #(.NLANES(2), .XLEN(32), .DEPTH(16), .DROP_W(16)) dut (
    .clock(clock), .reset_ni(reset_ni), .flush_i(flush_i), .in_valid(in_valid),
    .in_iaddr(in_iaddr), .in_insn(in_insn), .in_priv(in_priv), .in_exception(in_exception),
    .in_interrupt(in_interrupt), .in_cause(in_cause), .in_tval(in_tval), .in_time(in_time),
    .out_valid(out_valid), .out_ready(out_ready), .out_iaddr(out_iaddr), .out_insn(out_insn),
    .out_cause(out_cause), .out_tval(out_tval), .out_priv(out_priv), .out_exception(out_exception),
    .out_interrupt(out_interrupt), .out_lost(out_lost), .out_time(out_time), .level(level),
    .drop_count(drop_count));

  rocket_trace_buffer #(.NLANES(2), .XLEN(32), .DEPTH(16), .DROP_W(4)) dut4 (
    .clock(clock), .reset_ni(reset_ni), .flush_i(flush_i), .in_valid(in_valid),
    .in_iaddr(in_iaddr), .in_insn(in_insn), .in_priv(in_priv), .in_exception(in_exception),
    .in_interrupt(in_interrupt), .in_cause(in_cause), .in_tval(in_tval), .in_time(in_time),
    .out_valid(v4), .out_ready(out_ready), .out_iaddr(ia4), .out_insn(is4),
    .out_cause(ca4), .out_tval(tv4), .out_priv(pr4), .out_exception(ex4),
    .out_interrupt(it4), .out_lost(lo4), .out_time(ti4), .level(lv4),
    .drop_count(dc4));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] iaddr, insn, cause, tval;
    logic [2:0]  priv;
    logic        exc, intr, lost;
    logic [63:0] t;
  } rec_t;

  rec_t q[$];
  int   m_drops = 0;
  int   m_drops4 = 0;
  bit   m_pend = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_drops = 0;
    m_drops4 = 0;
    m_pend = 1'b0;
  endtask

  // Queue semantics: whole group in or whole group dropped, judged before the pop
  task automatic model_step();
    int   n, free;
    bit   pop, first;
    rec_t r, gone;
    if (flush_i) begin
      model_clear();
    end else begin
      n = $countones(in_valid);
      free = DP - q.size();
      pop = (q.size() != 0) && out_ready;
      if (pop) gone = q.pop_front();
      if (n > 0 && n <= free) begin
        first = 1'b1;
        for (int i = 0; i < NL; i++) begin
          if (in_valid[i]) begin
            r.iaddr = in_iaddr[i*32 +: 32];
            r.insn  = in_insn[i*32 +: 32];
            r.cause = in_cause[i*32 +: 32];
            r.tval  = in_tval[i*32 +: 32];
            r.priv  = in_priv[i*3 +: 3];
            r.exc   = in_exception[i];
            r.intr  = in_interrupt[i];
            r.lost  = first && m_pend;
            r.t     = TS ? in_time : 64'h0;
            first   = 1'b0;
            q.push_back(r);
          end
        end
        m_pend = 1'b0;
      end else if (n > 0) begin
        m_drops  = (m_drops + n > 65535) ? 65535 : m_drops + n;
        m_drops4 = (m_drops4 + n > 15) ? 15 : m_drops4 + n;
        m_pend   = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic rdy, input logic fl, input logic [63:0] t);
    in_valid     = v;
    in_iaddr     = {a1, a0};
    in_insn      = {~a1, ~a0};
    in_cause     = {a1 + 32'd1, a0 + 32'd1};
    in_tval      = {a1 ^ 32'hA5A5_0000, a0 ^ 32'hA5A5_0000};
    in_priv      = {a1[4:2], a0[4:2]};
    in_exception = {a1[2], a0[2]};
    in_interrupt = {a1[3], a0[3]};
    in_time      = t;
    out_ready    = rdy;
    flush_i      = fl;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic w(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1, input logic rdy);
    drive(v, a0, a1, rdy, 1'b0, {32'h0000_0ABC, a0 ^ a1});
  endtask

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clock);
      chk("out_valid", out_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("drop_count", drop_count, m_drops);
      chk("level_w4", lv4, q.size());
      chk("drop_count_w4", dc4, m_drops4);
      if (q.size() != 0) begin
        chk("out_iaddr", out_iaddr, q[0].iaddr);
        chk("out_insn", out_insn, q[0].insn);
        chk("out_cause", out_cause, q[0].cause);
        chk("out_tval", out_tval, q[0].tval);
        chk("out_priv", out_priv, q[0].priv);
        chk("out_exception", out_exception, q[0].exc);
        chk("out_interrupt", out_interrupt, q[0].intr);
        chk("out_lost", out_lost, q[0].lost);
        chk("out_time", out_time, q[0].t);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_level", level, 64'd0);
    chk("reset_valid", out_valid, 64'd0);
    chk("reset_drops", drop_count, 64'd0);
    reset_ni = 1'b1;

    // two lanes in, then two pops
    w(2'b11, 32'h1000, 32'h1004, 1'b0);
    chk("pair_level", level, 64'd2);
    chk("pair_head0", out_iaddr, 64'h1000);
    w(2'b00, 32'h0, 32'h0, 1'b1);
    chk("pair_head1", out_iaddr, 64'h1004);
    w(2'b00, 32'h0, 32'h0, 1'b1);
    chk("pair_empty", out_valid, 64'd0);

    // lane 1 only: no hole from lane 0
    w(2'b10, 32'h2000, 32'h2004, 1'b0);
    chk("lane1_level", level, 64'd1);
    chk("lane1_head", out_iaddr, 64'h2004);
    w(2'b00, 32'h0, 32'h0, 1'b1);

    // fill to 15, drop a pair while popping, then loss marking
    for (int i = 0; i < 7; i++) w(2'b11, 32'h100 + 32'(8*i), 32'h104 + 32'(8*i), 1'b0);
    w(2'b01, 32'h1F0, 32'h0, 1'b0);
    chk("fill15_level", level, 64'd15);
    w(2'b11, 32'h2F00, 32'h2F04, 1'b1);
    chk("drop_count2", drop_count, 64'd2);
    chk("drop_level14", level, 64'd14);
    w(2'b01, 32'h3000, 32'h0, 1'b0);
    w(2'b01, 32'h3004, 32'h0, 1'b0);
    chk("full_level", level, 64'd16);
    chk("full_valid", out_valid, 64'd1);
    for (int i = 0; i < 14; i++) w(2'b00, 32'h0, 32'h0, 1'b1);
    chk("lost_head", out_iaddr, 64'h3000);
    chk("lost_set", out_lost, 64'd1);
    w(2'b00, 32'h0, 32'h0, 1'b1);
    chk("lost_next_head", out_iaddr, 64'h3004);
    chk("lost_clear", out_lost, 64'd0);
    w(2'b00, 32'h0, 32'h0, 1'b1);

    // 20 single-lane writes streaming across the wrap
    for (int i = 0; i < 20; i++)
      w((i % 2 == 1) ? 2'b10 : 2'b01, 32'h4000 + 32'(8*i), 32'h4004 + 32'(8*i), 1'b1);
    chk("stream_drops", drop_count, 64'd2);
    chk("stream_level", level, 64'd1);
    w(2'b00, 32'h0, 32'h0, 1'b1);

    // fill, then nine pair drops to saturate the narrow counter
    for (int i = 0; i < 8; i++) w(2'b11, 32'h500 + 32'(8*i), 32'h504 + 32'(8*i), 1'b0);
    for (int i = 0; i < 9; i++) w(2'b11, 32'h5F00, 32'h5F04, 1'b0);
    chk("sat_w4", dc4, 64'hF);
    chk("sat_w16", drop_count, 64'd20);

    // flush with a full FIFO and a pair arriving
    drive(2'b11, 32'h7000, 32'h7004, 1'b1, 1'b1, 64'd7);
    chk("flush_level", level, 64'd0);
    chk("flush_valid", out_valid, 64'd0);
    chk("flush_drops", drop_count, 64'd0);
    chk("flush_drops_w4", dc4, 64'd0);
    w(2'b01, 32'h5000, 32'h0, 1'b0);
    chk("flush_no_lost", out_lost, 64'd0);
    chk("flush_head", out_iaddr, 64'h5000);
    w(2'b00, 32'h0, 32'h0, 1'b1);

    // timestamp shared by a pair
    drive(2'b11, 32'h6000, 32'h6004, 1'b0, 1'b0, 64'd100);
    chk("time0", out_time, TS ? 64'd100 : 64'd0);
    w(2'b00, 32'h0, 32'h0, 1'b1);
    chk("time1", out_time, TS ? 64'd100 : 64'd0);
    chk("time1_head", out_iaddr, 64'h6004);
    w(2'b00, 32'h0, 32'h0, 1'b1);

    // mid-stream async reset after a drop
    for (int i = 0; i < 9; i++) w(2'b11, 32'h800 + 32'(8*i), 32'h804 + 32'(8*i), 1'b0);
    chk("pre_reset_drops", drop_count, 64'd2);
    #2;
    reset_ni = 1'b0;
    model_clear();
    @(negedge clock);
    chk("rst_level", level, 64'd0);
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_drops", drop_count, 64'd0);
    reset_ni = 1'b1;
    w(2'b11, 32'h9000, 32'h9004, 1'b1);
    chk("post_reset_head", out_iaddr, 64'h9000);
    w(2'b00, 32'h0, 32'h0, 1'b1);
    w(2'b00, 32'h0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
